// File: rtl/tile_fifo_mc.sv
`default_nettype none
// ============================================================================
// Module   : tile_fifo_mc
// Brief    : Multi-lane tile FIFO between the tile loader and the array
//            feeders. Each lane is an independent first-word-fall-through
//            queue of whole tiles with an occupancy count, an almost-full
//            flag and a synchronous per-lane flush.
// Revision : 1.0 - initial release
// ============================================================================
module tile_fifo_mc #(
    parameter  int WIDTH     = 16,
    parameter  int ELEMS     = 16,
    parameter  int DEPTH     = 4,
    parameter  int NUM_CH    = 2,
    parameter  int AF_THRESH = DEPTH - 1,
    localparam int TW        = WIDTH * ELEMS,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_CH-1:0]    flush,
    input  logic [NUM_CH-1:0]    in_valid,
    output logic [NUM_CH-1:0]    in_ready,
    input  logic [NUM_CH*TW-1:0] in_data,
    output logic [NUM_CH-1:0]    out_valid,
    input  logic [NUM_CH-1:0]    out_ready,
    output logic [NUM_CH*TW-1:0] out_data,
    output logic [NUM_CH*CW-1:0] count,
    output logic [NUM_CH-1:0]    almost_full
);

    localparam int             c_ptr_w = $clog2(DEPTH);
    localparam logic [CW-1:0]  c_full  = CW'(DEPTH);
    localparam logic [CW-1:0]  c_af    = CW'(AF_THRESH);
    localparam logic [c_ptr_w-1:0] c_last = c_ptr_w'(DEPTH - 1);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        logic [TW-1:0]      r_mem [DEPTH];
        logic [c_ptr_w-1:0] r_rd_ptr;
        logic [c_ptr_w-1:0] r_wr_ptr;
        logic [CW-1:0]      r_cnt;

        logic               w_in_ready;
        logic               w_out_valid;
        logic               w_push;
        logic               w_pop;
        logic [c_ptr_w-1:0] w_rd_next;
        logic [c_ptr_w-1:0] w_wr_next;

        // Handshake status comes only from registered occupancy, so a full
        // lane refuses a push even if it is being popped this cycle.
        assign w_in_ready  = (r_cnt != c_full);
        assign w_out_valid = (r_cnt != '0);
        assign w_push      = in_valid[c] & w_in_ready;
        assign w_pop       = out_valid[c] & out_ready[c];

        // Explicit wrap so that non-power-of-two depths work.
        assign w_rd_next = (r_rd_ptr == c_last) ? '0 : r_rd_ptr + c_ptr_w'(1);
        assign w_wr_next = (r_wr_ptr == c_last) ? '0 : r_wr_ptr + c_ptr_w'(1);

        // Pointer and occupancy update; flush wins over push and pop.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_cnt    <= '0;
            end else if (flush[c]) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_cnt    <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= w_wr_next;
                end
                if (w_pop) begin
                    r_rd_ptr <= w_rd_next;
                end
                if (w_push && !w_pop) begin
                    r_cnt <= r_cnt + CW'(1);
                end else if (w_pop && !w_push) begin
                    r_cnt <= r_cnt - CW'(1);
                end
            end
        end

        // Tile storage is data only and carries no reset.
        always_ff @(posedge clk) begin
            if (w_push && !flush[c]) begin
                r_mem[r_wr_ptr] <= in_data[c*TW +: TW];
            end
        end

        assign in_ready[c]              = w_in_ready;
        assign out_valid[c]             = w_out_valid;
        assign out_data[c*TW +: TW]     = w_out_valid ? r_mem[r_rd_ptr] : '0;
        assign count[c*CW +: CW]        = r_cnt;
        assign almost_full[c]           = (r_cnt >= c_af);
    end

endmodule
`default_nettype wire

// File: tb/tb_tile_fifo_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_tile_fifo_mc
// Brief    : Self-checking bench for tile_fifo_mc. Drives a DEPTH=4 two-lane
//            instance and a DEPTH=3 single-lane instance against queue-based
//            reference lanes (index 0,1 = first instance, 2 = second).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tile_fifo_mc;

    localparam int WIDTH = 16;
    localparam int ELEMS = 16;
    localparam int TW    = WIDTH * ELEMS;
    localparam int CWA   = $clog2(4 + 1);
    localparam int CWB   = $clog2(3 + 1);
    localparam int NL    = 3;

    logic clk;
    logic reset_n;

    // per-reference-lane stimulus
    logic          vld [NL];
    logic          rdy [NL];
    logic          fl  [NL];
    logic [TW-1:0] dat [NL];

    logic [1:0]      a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_af;
    logic [2*TW-1:0] a_in_data, a_out_data;
    logic [2*CWA-1:0] a_count;

    logic [0:0]      b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_af;
    logic [TW-1:0]   b_in_data, b_out_data;
    logic [CWB-1:0]  b_count;

    assign a_flush     = {fl[1], fl[0]};
    assign a_in_valid  = {vld[1], vld[0]};
    assign a_out_ready = {rdy[1], rdy[0]};
    assign a_in_data   = {dat[1], dat[0]};
    assign b_flush     = fl[2];
    assign b_in_valid  = vld[2];
    assign b_out_ready = rdy[2];
    assign b_in_data   = dat[2];

    tile_fifo_mc #(.WIDTH(WIDTH), .ELEMS(ELEMS), .DEPTH(4), .NUM_CH(2)) dut_a (
        .clk(clk), .reset_n(reset_n), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .count(a_count), .almost_full(a_af)
    );

    tile_fifo_mc #(.WIDTH(WIDTH), .ELEMS(ELEMS), .DEPTH(3), .NUM_CH(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .count(b_count), .almost_full(b_af)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference: one queue of tiles per lane
    logic [TW-1:0] q [NL][$];
    int n_tests = 0;
    int n_fail  = 0;

    function automatic int dep(int c);
        return (c < 2) ? 4 : 3;
    endfunction

    function automatic int afth(int c);
        return dep(c) - 1;
    endfunction

    function automatic logic [TW-1:0] rnd_tile();
        logic [TW-1:0] r;
        for (int i = 0; i < TW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic check(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < NL; c++) begin
            int            sz;
            logic          ov, ir, af;
            int            cn;
            logic [TW-1:0] od, exp_od;
            sz = q[c].size();
            exp_od = (sz != 0) ? q[c][0] : '0;
            if (c < 2) begin
                ov = a_out_valid[c]; ir = a_in_ready[c]; af = a_af[c];
                cn = int'(a_count[c*CWA +: CWA]); od = a_out_data[c*TW +: TW];
            end else begin
                ov = b_out_valid[0]; ir = b_in_ready[0]; af = b_af[0];
                cn = int'(b_count); od = b_out_data;
            end
            check($sformatf("lane%0d out_valid", c), TW'(ov), TW'(sz != 0));
            check($sformatf("lane%0d in_ready", c), TW'(ir), TW'(sz != dep(c)));
            check($sformatf("lane%0d count", c), TW'(cn), TW'(sz));
            check($sformatf("lane%0d almost_full", c), TW'(af), TW'(sz >= afth(c)));
            check($sformatf("lane%0d out_data", c), od, exp_od);
        end
    endtask

    // one clock: decide acceptance from pre-edge state, apply at the edge, check
    task automatic step();
        bit push [NL];
        bit pop  [NL];
        for (int c = 0; c < NL; c++) begin
            push[c] = vld[c] && (q[c].size() != dep(c));
            pop[c]  = rdy[c] && (q[c].size() != 0);
        end
        @(posedge clk);
        for (int c = 0; c < NL; c++) begin
            if (fl[c]) begin
                q[c].delete();
            end else begin
                if (pop[c])  void'(q[c].pop_front());
                if (push[c]) q[c].push_back(dat[c]);
            end
        end
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        for (int c = 0; c < NL; c++) begin
            vld[c] = 1'b0; rdy[c] = 1'b0; fl[c] = 1'b0; dat[c] = '0;
        end
    endtask

    initial begin
        idle_inputs();
        reset_n = 1'b0;
        #2;
        check_all();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // fill lane 0 with 0xA0..0xA3, then one extra push attempt while full
        for (int i = 0; i < 5; i++) begin
            vld[0] = 1'b1;
            dat[0] = TW'(8'hA0 + i);
            step();
        end
        idle_inputs();

        // drain lane 0, plus extra pops on an empty lane
        rdy[0] = 1'b1;
        repeat (6) step();
        idle_inputs();

        // DEPTH=3 lane: prime with one tile, then continuous push+pop across wrap
        vld[2] = 1'b1; dat[2] = rnd_tile();
        step();
        rdy[2] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            dat[2] = rnd_tile();
            step();
        end
        idle_inputs();

        // full lane with push+pop: pop only
        for (int i = 0; i < 4; i++) begin
            vld[0] = 1'b1; dat[0] = rnd_tile();
            step();
        end
        vld[0] = 1'b1; rdy[0] = 1'b1; dat[0] = rnd_tile();
        step();
        // drain, then empty lane with push+pop: push only
        vld[0] = 1'b0;
        repeat (3) step();
        vld[0] = 1'b1; dat[0] = rnd_tile();
        step();
        idle_inputs();

        // flush lane 1 at count 2 while lane 0 pushes
        vld[1] = 1'b1;
        repeat (2) begin
            dat[1] = rnd_tile();
            step();
        end
        fl[1] = 1'b1; vld[1] = 1'b1; dat[1] = rnd_tile();
        vld[0] = 1'b1; dat[0] = rnd_tile();
        step();
        idle_inputs();
        step();

        // randomized traffic on all lanes with occasional flushes
        for (int i = 0; i < 300; i++) begin
            for (int c = 0; c < NL; c++) begin
                vld[c] = 1'($urandom_range(0, 1));
                rdy[c] = 1'($urandom_range(0, 1));
                fl[c]  = ($urandom_range(0, 15) == 0);
                dat[c] = rnd_tile();
            end
            step();
        end
        idle_inputs();

        // build up some content, then assert reset between edges
        for (int c = 0; c < NL; c++) vld[c] = 1'b1;
        repeat (2) begin
            for (int c = 0; c < NL; c++) dat[c] = rnd_tile();
            step();
        end
        idle_inputs();
        #2 reset_n = 1'b0;
        #1;
        for (int c = 0; c < NL; c++) q[c].delete();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        reset_n = 1'b1;

        // traffic resumes cleanly after reset
        for (int c = 0; c < NL; c++) begin
            vld[c] = 1'b1; rdy[c] = 1'b1; dat[c] = rnd_tile();
        end
        repeat (3) step();
        idle_inputs();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
